// File: rtl/if_stage_if.sv
// Instruction-fetch stage bus: memory read data, redirect, hazard inputs and IF/ID outputs.
// Latency: none (signal bundle only).
// Backpressure: none here; the stage stalls itself on a load-use hazard.
interface if_stage_if;
  logic [31:0] instrdatain;
  logic        branchtaken;
  logic [31:0] branchtarget;
  logic        idexmemread;
  logic [4:0]  idexrt;
  logic [31:0] pc;
  logic [31:0] addressout;
  logic [31:0] instructionout;
  logic        validout;
  logic        stall;
  logic [15:0] stallcount;

  // Surrounding pipeline / memory side
  modport master (
    output instrdatain, branchtaken, branchtarget, idexmemread, idexrt,
    input  pc, addressout, instructionout, validout, stall, stallcount
  );

  // Fetch stage side
  modport slave (
    input  instrdatain, branchtaken, branchtarget, idexmemread, idexrt,
    output pc, addressout, instructionout, validout, stall, stallcount
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, load-use hazard detect.
// Latency: 1 cycle fetch-to-IF/ID; a redirect leaves exactly one bubble in IF/ID.
// Backpressure: load-use hazard holds PC and IF/ID; a redirect overrides the hold.
module if_stage (
  input  logic      clk,
  input  logic      reset,
  if_stage_if.slave bus
);

  logic [31:0] pcreg;
  logic [31:0] addrreg;
  logic [31:0] instrreg;
  logic        validreg;
  logic [15:0] countreg;
  logic        hazard;
  logic [31:0] pcnext;

  // Sequential next address; 32-bit add wraps 0xFFFFFFFC to 0 naturally
  assign pcnext = pcreg + 32'd4;

  // Load-use hazard: only a real instruction in IF/ID can stall, and r0 never does
  always_comb begin
    hazard = 1'b0;
    if (validreg && bus.idexmemread && (bus.idexrt != 5'd0) &&
        ((bus.idexrt == instrreg[25:21]) || (bus.idexrt == instrreg[20:16]))) begin
      hazard = 1'b1;
    end
  end

  // PC and IF/ID update: redirect flushes and wins over a stall, stall holds, else fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcreg    <= 32'd0;
      addrreg  <= 32'd0;
      instrreg <= 32'd0;
      validreg <= 1'b0;
    end else if (bus.branchtaken) begin
      pcreg    <= {bus.branchtarget[31:2], 2'b00};
      addrreg  <= 32'd0;
      instrreg <= 32'd0;
      validreg <= 1'b0;
    end else if (!hazard) begin
      pcreg    <= pcnext;
      addrreg  <= pcnext;
      instrreg <= bus.instrdatain;
      validreg <= 1'b1;
    end
  end

  // Saturating count of cycles actually lost to a stall (redirects don't count)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      countreg <= 16'd0;
    end else if (hazard && !bus.branchtaken && (countreg != 16'hFFFF)) begin
      countreg <= countreg + 16'd1;
    end
  end

  assign bus.pc             = pcreg;
  assign bus.addressout     = addrreg;
  assign bus.instructionout = instrreg;
  assign bus.validout       = validreg;
  assign bus.stall          = hazard;
  assign bus.stallcount     = countreg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences, random vs model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: stall is checked half a cycle before the edge it affects.
module tb_if_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] mem [0:63];

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational instruction memory, word-indexed by pc
  assign bus.instrdatain = mem[bus.pc[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bt;
    logic [31:0] tgt;
    logic        mr;
    logic [4:0]  rt;
    logic        xstall;
    logic [31:0] xpc;
    logic [31:0] xaddr;
    logic [31:0] xinstr;
    logic        xvld;
    logic [15:0] xcnt;
  } vec_t;

  vec_t tbl [13];

  // Reference model state
  logic [31:0] m_pc, m_addr, m_instr;
  logic        m_vld;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic bt, input logic [31:0] tgt, input logic mr, input logic [4:0] rt);
    bus.branchtaken  = bt;
    bus.branchtarget = tgt;
    bus.idexmemread  = mr;
    bus.idexrt       = rt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    m_pc = 0; m_addr = 0; m_instr = 0; m_vld = 0; m_cnt = 0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] xpc, input logic [31:0] xaddr,
                           input logic [31:0] xinstr, input logic xvld, input logic [15:0] xcnt);
    chk({tag, ".pc"}, bus.pc, xpc);
    chk({tag, ".addressout"}, bus.addressout, xaddr);
    chk({tag, ".instructionout"}, bus.instructionout, xinstr);
    chk({tag, ".validout"}, {31'd0, bus.validout}, {31'd0, xvld});
    chk({tag, ".stallcount"}, {16'd0, bus.stallcount}, {16'd0, xcnt});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = {6'd0, 5'(i + 1), 5'(i + 2), 16'(i)};
    drive(1'b0, 32'd0, 1'b0, 5'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    // Reset state, before any clock edge
    chk_state("reset", 32'd0, 32'd0, 32'd0, 1'b0, 16'd0);
    chk("reset.stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table: mem[i] has rs=i+1, rt=i+2
    tbl[0]  = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h4,        32'h4,  mem[0],  1'b1, 16'd0};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h8,        32'h8,  mem[1],  1'b1, 16'd0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'hC,        32'hC,  mem[2],  1'b1, 16'd0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 5'd0, 1'b0, 32'h10,       32'h10, mem[3],  1'b1, 16'd0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 5'd5, 1'b1, 32'h10,       32'h10, mem[3],  1'b1, 16'd1};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 5'd4, 1'b1, 32'h10,       32'h10, mem[3],  1'b1, 16'd2};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 5'd4, 1'b0, 32'h14,       32'h14, mem[4],  1'b1, 16'd2};
    tbl[7]  = '{1'b1, 32'h40,       1'b1, 5'd6, 1'b1, 32'h40,       32'h0,  32'h0,   1'b0, 16'd2};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 5'd1, 1'b0, 32'h44,       32'h44, mem[16], 1'b1, 16'd2};
    tbl[9]  = '{1'b1, 32'h43,       1'b0, 5'd0, 1'b0, 32'h40,       32'h0,  32'h0,   1'b0, 16'd2};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h44,       32'h44, mem[16], 1'b1, 16'd2};
    tbl[11] = '{1'b1, 32'hFFFFFFFE, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFC, 32'h0,  32'h0,   1'b0, 16'd2};
    tbl[12] = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        32'h0,  mem[63], 1'b1, 16'd2};

    for (int v = 0; v < 13; v++) begin
      drive(tbl[v].bt, tbl[v].tgt, tbl[v].mr, tbl[v].rt);
      #1 chk($sformatf("vec%0d.stall", v), {31'd0, bus.stall}, {31'd0, tbl[v].xstall});
      @(posedge clk);
      @(negedge clk);
      chk_state($sformatf("vec%0d", v), tbl[v].xpc, tbl[v].xaddr, tbl[v].xinstr, tbl[v].xvld, tbl[v].xcnt);
    end

    // Async reset asserted between edges while stalled
    do_reset();
    drive(1'b0, 32'd0, 1'b0, 5'd0);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 32'd0, 1'b1, 5'd1);
    @(posedge clk); @(negedge clk);
    chk("arst.precount", {16'd0, bus.stallcount}, 32'd1);
    chk("arst.prestall", {31'd0, bus.stall}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_state("arst", 32'd0, 32'd0, 32'd0, 1'b0, 16'd0);
    chk("arst.stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Saturation: hold a hazard on mem[0] (rs=1) well past 65535 cycles
    drive(1'b0, 32'd0, 1'b0, 5'd0);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 32'd0, 1'b1, 5'd1);
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk);
      if (n == 65534 || n == 65535) begin
        @(negedge clk);
        chk($sformatf("sat.count%0d", n), {16'd0, bus.stallcount}, (n == 65534) ? 32'h0000FFFE : 32'h0000FFFF);
      end
    end
    @(negedge clk);
    chk_state("sat.end", 32'h4, 32'h4, mem[0], 1'b1, 16'hFFFF);

    // Randomized run against the reference model
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic        bt, mr, xs;
      logic [31:0] tgt;
      logic [4:0]  rt;
      bt  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
      mr  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       rt = 5'd0;
        1:       rt = m_instr[25:21];
        2:       rt = m_instr[20:16];
        default: rt = 5'($urandom);
      endcase
      drive(bt, tgt, mr, rt);
      xs = m_vld && mr && (rt != 0) && (rt == m_instr[25:21] || rt == m_instr[20:16]);
      #1 chk($sformatf("rnd%0d.stall", c), {31'd0, bus.stall}, {31'd0, xs});
      if (bt) begin
        m_pc = tgt & ~32'd3; m_addr = 0; m_instr = 0; m_vld = 0;
      end else if (!xs) begin
        m_instr = mem[m_pc[7:2]];
        m_addr  = m_pc + 32'd4;
        m_pc    = m_addr;
        m_vld   = 1'b1;
      end else if (m_cnt != 16'hFFFF) begin
        m_cnt = m_cnt + 16'd1;
      end
      @(posedge clk);
      @(negedge clk);
      chk_state($sformatf("rnd%0d", c), m_pc, m_addr, m_instr, m_vld, m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
